// File: rtl/systolic_array_stream.sv
// Output-stationary ROWSxCOLS GEMM engine: a start/done job FSM, a valid/ready operand stream
// with valid-tagged skew, saturating accumulators, and a row-serial valid/ready result drain.
module systolic_array_stream #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int IP_W  = 8,
  parameter int ACC_W = 32,
  parameter int K_MAX = 256,
  parameter int KW    = $clog2(K_MAX + 1),
  parameter int RW    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [KW-1:0]         k_len,
  input  logic                  signed_mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ROWS*IP_W-1:0]  in_x,
  input  logic [COLS*IP_W-1:0]  in_w,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [COLS*ACC_W-1:0] out_data,
  output logic [RW-1:0]         out_row,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  sat_flag,
  output logic [31:0]           cycles_count
);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DRAIN} state_t;
  localparam int FW = $clog2(ROWS + COLS);

  state_t          state, state_nxt;
  logic [KW-1:0]   k_reg, beat_cnt;
  logic [FW-1:0]   flush_cnt;
  logic [RW-1:0]   row;
  logic            sm;
  logic            start_ok, beat, last_beat, flush_end, drain_hs, sat_any;

  logic [IP_W-1:0]  x_sk  [ROWS][ROWS];
  logic             xv_sk [ROWS][ROWS];
  logic [IP_W-1:0]  w_sk  [COLS][COLS];
  logic             wv_sk [COLS][COLS];
  logic [IP_W-1:0]  x_pe  [ROWS][COLS];
  logic             xv_pe [ROWS][COLS];
  logic [IP_W-1:0]  w_pe  [ROWS][COLS];
  logic             wv_pe [ROWS][COLS];
  logic [IP_W-1:0]  x_in  [ROWS][COLS];
  logic             xv_in [ROWS][COLS];
  logic [IP_W-1:0]  w_in  [ROWS][COLS];
  logic             wv_in [ROWS][COLS];
  logic [ACC_W-1:0] acc     [ROWS][COLS];
  logic [ACC_W-1:0] acc_nxt [ROWS][COLS];

  assign start_ok  = (state == IDLE) && start && (k_len != '0);
  assign in_ready  = (state == STREAM);
  assign beat      = in_valid && in_ready;
  assign last_beat = beat && (beat_cnt == k_reg - 1'b1);
  assign flush_end = (state == FLUSH) && (flush_cnt == FW'(ROWS + COLS - 2));
  assign out_valid = (state == DRAIN);
  assign drain_hs  = out_valid && out_ready;
  assign out_row   = row;
  assign out_last  = out_valid && (row == RW'(ROWS - 1));
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_ok) state_nxt = STREAM;
      STREAM:  if (last_beat) state_nxt = FLUSH;
      FLUSH:   if (flush_end) state_nxt = DRAIN;
      DRAIN:   if (drain_hs && out_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      k_reg        <= '0;
      sm           <= 1'b0;
      beat_cnt     <= '0;
      flush_cnt    <= '0;
      row          <= '0;
      done         <= 1'b0;
      cycles_count <= '0;
    end else begin
      state <= state_nxt;
      done  <= drain_hs && out_last;
      if (start_ok) begin
        k_reg        <= k_len;
        sm           <= signed_mode;
        cycles_count <= '0;
        beat_cnt     <= '0;
        flush_cnt    <= '0;
        row          <= '0;
      end else if (busy) begin
        cycles_count <= cycles_count + 32'd1;
      end
      if (beat) beat_cnt <= beat_cnt + 1'b1;
      if (state == FLUSH) flush_cnt <= flush_cnt + 1'b1;
      if (drain_hs) row <= out_last ? '0 : row + 1'b1;
    end
  end

  // Operands are widened to ACC_W+1 bits so the carry/sign bit of the sum exposes overflow.
  always_comb begin
    logic [ACC_W:0] xe, we, prod, ae, sum;
    sat_any = 1'b0;
    xe = '0; we = '0; prod = '0; ae = '0; sum = '0;
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < COLS; j++) begin
        if (j == 0) begin
          if (i == 0) begin
            x_in[i][j]  = beat ? in_x[IP_W-1:0] : '0;
            xv_in[i][j] = beat;
          end else begin
            x_in[i][j]  = x_sk[i][(i > 0) ? i - 1 : 0];
            xv_in[i][j] = xv_sk[i][(i > 0) ? i - 1 : 0];
          end
        end else begin
          x_in[i][j]  = x_pe[i][(j > 0) ? j - 1 : 0];
          xv_in[i][j] = xv_pe[i][(j > 0) ? j - 1 : 0];
        end
        if (i == 0) begin
          if (j == 0) begin
            w_in[i][j]  = beat ? in_w[IP_W-1:0] : '0;
            wv_in[i][j] = beat;
          end else begin
            w_in[i][j]  = w_sk[j][(j > 0) ? j - 1 : 0];
            wv_in[i][j] = wv_sk[j][(j > 0) ? j - 1 : 0];
          end
        end else begin
          w_in[i][j]  = w_pe[(i > 0) ? i - 1 : 0][j];
          wv_in[i][j] = wv_pe[(i > 0) ? i - 1 : 0][j];
        end

        xe   = sm ? {{(ACC_W + 1 - IP_W){x_in[i][j][IP_W-1]}}, x_in[i][j]}
                  : {{(ACC_W + 1 - IP_W){1'b0}}, x_in[i][j]};
        we   = sm ? {{(ACC_W + 1 - IP_W){w_in[i][j][IP_W-1]}}, w_in[i][j]}
                  : {{(ACC_W + 1 - IP_W){1'b0}}, w_in[i][j]};
        prod = xe * we;
        ae   = {sm & acc[i][j][ACC_W-1], acc[i][j]};
        sum  = ae + prod;
        acc_nxt[i][j] = acc[i][j];
        if (xv_in[i][j] && wv_in[i][j]) begin
          if (sm && (sum[ACC_W] != sum[ACC_W-1])) begin
            acc_nxt[i][j] = sum[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}} : {1'b0, {(ACC_W - 1){1'b1}}};
            sat_any = 1'b1;
          end else if (!sm && sum[ACC_W]) begin
            acc_nxt[i][j] = '1;
            sat_any = 1'b1;
          end else begin
            acc_nxt[i][j] = sum[ACC_W-1:0];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_flag <= 1'b0;
      for (int i = 0; i < ROWS; i++)
        for (int s = 0; s < ROWS; s++) begin
          x_sk[i][s]  <= '0;
          xv_sk[i][s] <= 1'b0;
        end
      for (int j = 0; j < COLS; j++)
        for (int s = 0; s < COLS; s++) begin
          w_sk[j][s]  <= '0;
          wv_sk[j][s] <= 1'b0;
        end
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++) begin
          x_pe[i][j]  <= '0;
          xv_pe[i][j] <= 1'b0;
          w_pe[i][j]  <= '0;
          wv_pe[i][j] <= 1'b0;
          acc[i][j]   <= '0;
        end
    end else begin
      if (start_ok) sat_flag <= 1'b0;
      else if (sat_any) sat_flag <= 1'b1;
      // Idle cycles push invalid zero tokens so bubbles never reach an accumulator.
      for (int i = 0; i < ROWS; i++)
        for (int s = 0; s < ROWS; s++) begin
          if (s == 0) begin
            x_sk[i][s]  <= beat ? in_x[i*IP_W +: IP_W] : '0;
            xv_sk[i][s] <= beat;
          end else begin
            x_sk[i][s]  <= x_sk[i][(s > 0) ? s - 1 : 0];
            xv_sk[i][s] <= xv_sk[i][(s > 0) ? s - 1 : 0];
          end
        end
      for (int j = 0; j < COLS; j++)
        for (int s = 0; s < COLS; s++) begin
          if (s == 0) begin
            w_sk[j][s]  <= beat ? in_w[j*IP_W +: IP_W] : '0;
            wv_sk[j][s] <= beat;
          end else begin
            w_sk[j][s]  <= w_sk[j][(s > 0) ? s - 1 : 0];
            wv_sk[j][s] <= wv_sk[j][(s > 0) ? s - 1 : 0];
          end
        end
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++) begin
          x_pe[i][j]  <= x_in[i][j];
          xv_pe[i][j] <= xv_in[i][j];
          w_pe[i][j]  <= w_in[i][j];
          wv_pe[i][j] <= wv_in[i][j];
          acc[i][j]   <= start_ok ? '0 : acc_nxt[i][j];
        end
    end
  end

  always_comb begin
    out_data = '0;
    for (int j = 0; j < COLS; j++) out_data[j*ACC_W +: ACC_W] = acc[row][j];
  end

endmodule

// File: tb/tb_systolic_array_stream.sv
// Directed bench for systolic_array_stream: a 32-bit instance for the main jobs and a 16-bit
// instance sharing the same stimulus for the saturation jobs.
module tb_systolic_array_stream;
  localparam int ROWS = 4, COLS = 4, IP_W = 8, KW = 9, RW = 2;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, signed_mode = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b1;
  logic [KW-1:0] k_len = '0;
  logic [ROWS*IP_W-1:0] in_x = '0;
  logic [COLS*IP_W-1:0] in_w = '0;

  logic d_in_ready, d_out_valid, d_out_last, d_busy, d_done, d_sat;
  logic [COLS*32-1:0] d_out_data;
  logic [RW-1:0] d_out_row;
  logic [31:0] d_cycles;
  logic s_in_ready, s_out_valid, s_out_last, s_busy, s_done, s_sat;
  logic [COLS*16-1:0] s_out_data;
  logic [RW-1:0] s_out_row;
  logic [31:0] s_cycles;

  int n_cmp = 0, n_err = 0, d_done_cnt = 0, dc0 = 0;
  bit sat_sel = 1'b0;
  logic [31:0] exp_c [ROWS][COLS];
  logic [ROWS*IP_W-1:0] bx [8];
  logic [COLS*IP_W-1:0] bw [8];

  systolic_array_stream #(.ROWS(ROWS), .COLS(COLS), .IP_W(IP_W), .ACC_W(32), .K_MAX(256)) u_dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .signed_mode(signed_mode),
    .in_valid(in_valid), .in_ready(d_in_ready), .in_x(in_x), .in_w(in_w),
    .out_valid(d_out_valid), .out_ready(out_ready), .out_data(d_out_data), .out_row(d_out_row),
    .out_last(d_out_last), .busy(d_busy), .done(d_done), .sat_flag(d_sat), .cycles_count(d_cycles));

  systolic_array_stream #(.ROWS(ROWS), .COLS(COLS), .IP_W(IP_W), .ACC_W(16), .K_MAX(256)) u_sat (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .signed_mode(signed_mode),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_x(in_x), .in_w(in_w),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_row(s_out_row),
    .out_last(s_out_last), .busy(s_busy), .done(s_done), .sat_flag(s_sat), .cycles_count(s_cycles));

  always #5 clk = ~clk;
  always @(posedge clk) if (d_done) d_done_cnt <= d_done_cnt + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] ov();    return 64'(sat_sel ? s_out_valid : d_out_valid); endfunction
  function automatic logic [63:0] orow();  return 64'(sat_sel ? s_out_row   : d_out_row);   endfunction
  function automatic logic [63:0] olast(); return 64'(sat_sel ? s_out_last  : d_out_last);  endfunction
  function automatic logic [63:0] odone(); return 64'(sat_sel ? s_done      : d_done);      endfunction
  function automatic logic [63:0] obusy(); return 64'(sat_sel ? s_busy      : d_busy);      endfunction
  function automatic logic [63:0] osat();  return 64'(sat_sel ? s_sat       : d_sat);       endfunction
  function automatic logic [63:0] ocyc();  return 64'(sat_sel ? s_cycles    : d_cycles);    endfunction
  function automatic logic [63:0] col(input int j);
    return sat_sel ? 64'(s_out_data[j*16 +: 16]) : 64'(d_out_data[j*32 +: 32]);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ident();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < ROWS; i++) bx[k][i*IP_W +: IP_W] = (i == k) ? 8'd1 : 8'd0;
      for (int j = 0; j < COLS; j++) bw[k][j*IP_W +: IP_W] = 8'(4 * k + j + 1);
    end
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++) exp_c[i][j] = 32'(4 * i + j + 1);
  endtask

  task automatic load_const(input logic [7:0] x, input logic [7:0] w, input logic [31:0] c);
    for (int k = 0; k < 8; k++) begin
      bx[k] = {ROWS{x}};
      bw[k] = {COLS{w}};
    end
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++) exp_c[i][j] = c;
  endtask

  task automatic start_job(input int k, input bit sm);
    start = 1'b1; k_len = KW'(k); signed_mode = sm;
    tick();
    start = 1'b0;
  endtask

  task automatic stream(input int nb, input bit bub);
    for (int b = 0; b < nb; b++) begin
      if (bub && b > 0) begin
        in_valid = 1'b0;
        tick();
      end
      in_valid = 1'b1; in_x = bx[b]; in_w = bw[b];
      tick();
    end
    in_valid = 1'b0; in_x = '0; in_w = '0;
  endtask

  task automatic drain(input string tag, input int stall_row, input int stall_n);
    int t = 0;
    while (ov() == 64'd0 && t < 60) begin
      tick();
      t++;
    end
    chk($sformatf("%s.valid", tag), ov(), 64'd1);
    for (int r = 0; r < ROWS; r++) begin
      if (r == stall_row) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          tick();
          chk($sformatf("%s.stall%0d.row", tag, s), orow(), 64'(r));
          chk($sformatf("%s.stall%0d.last", tag, s), olast(), 64'(r == ROWS - 1));
          for (int j = 0; j < COLS; j++)
            chk($sformatf("%s.stall%0d.c%0d", tag, s, j), col(j), 64'(exp_c[r][j]));
        end
        out_ready = 1'b1;
      end
      chk($sformatf("%s.row%0d", tag, r), orow(), 64'(r));
      chk($sformatf("%s.last%0d", tag, r), olast(), 64'(r == ROWS - 1));
      for (int j = 0; j < COLS; j++)
        chk($sformatf("%s.c%0d%0d", tag, r, j), col(j), 64'(exp_c[r][j]));
      tick();
    end
    chk($sformatf("%s.done", tag), odone(), 64'd1);
    chk($sformatf("%s.busy_end", tag), obusy(), 64'd0);
    chk($sformatf("%s.valid_end", tag), ov(), 64'd0);
    tick();
    chk($sformatf("%s.done_pulse", tag), odone(), 64'd0);
  endtask

  initial begin
    tick(); tick();
    chk("rst.in_ready", 64'(d_in_ready), 64'd0);
    chk("rst.out_valid", ov(), 64'd0);
    chk("rst.out_data", 64'(d_out_data[63:0]), 64'd0);
    chk("rst.out_row", orow(), 64'd0);
    chk("rst.out_last", olast(), 64'd0);
    chk("rst.busy", obusy(), 64'd0);
    chk("rst.done", odone(), 64'd0);
    chk("rst.sat", osat(), 64'd0);
    chk("rst.cycles", ocyc(), 64'd0);
    rst = 1'b0;

    load_ident();
    start_job(4, 1'b0);
    chk("t1.busy", obusy(), 64'd1);
    chk("t1.in_ready", 64'(d_in_ready), 64'd1);
    chk("t1.cycles0", ocyc(), 64'd0);
    stream(4, 1'b0);
    chk("t1.flush_rdy", 64'(d_in_ready), 64'd0);
    drain("t1", -1, 0);
    chk("t1.cycles", ocyc(), 64'd15);
    chk("t1.sat", osat(), 64'd0);

    load_ident();
    start_job(4, 1'b0);
    stream(4, 1'b1);
    drain("t2", -1, 0);
    chk("t2.cycles", ocyc(), 64'd18);

    load_const(8'hFF, 8'h02, 32'hFFFF_FFFA);
    start_job(3, 1'b1);
    stream(3, 1'b0);
    drain("t3s", -1, 0);
    chk("t3s.sat", osat(), 64'd0);
    load_const(8'hFF, 8'h02, 32'd1530);
    start_job(3, 1'b0);
    stream(3, 1'b0);
    drain("t3u", -1, 0);
    chk("t3u.sat", osat(), 64'd0);

    sat_sel = 1'b1;
    load_const(8'hFF, 8'hFF, 32'h0000_FFFF);
    start_job(2, 1'b0);
    stream(2, 1'b0);
    drain("t4u", -1, 0);
    chk("t4u.sat", osat(), 64'd1);
    load_const(8'h80, 8'h80, 32'h0000_7FFF);
    start_job(2, 1'b1);
    chk("t4s.sat_clr", osat(), 64'd0);
    stream(2, 1'b0);
    drain("t4s", -1, 0);
    chk("t4s.sat", osat(), 64'd1);
    load_const(8'h03, 8'h05, 32'd15);
    start_job(1, 1'b0);
    stream(1, 1'b0);
    drain("t4n", -1, 0);
    chk("t4n.sat", osat(), 64'd0);
    sat_sel = 1'b0;

    load_ident();
    start_job(4, 1'b0);
    stream(4, 1'b0);
    drain("t5", 1, 3);
    chk("t5.cycles", ocyc(), 64'd18);

    load_ident();
    start_job(4, 1'b0);
    stream(2, 1'b0);
    dc0 = d_done_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6.abort_busy", obusy(), 64'd0);
    chk("t6.abort_rdy", 64'(d_in_ready), 64'd0);
    chk("t6.abort_cycles", ocyc(), 64'd0);
    repeat (30) tick();
    chk("t6.no_done", 64'(d_done_cnt), 64'(dc0));
    start_job(0, 1'b0);
    chk("t6.k0_busy", obusy(), 64'd0);
    tick();
    chk("t6.k0_busy2", obusy(), 64'd0);
    load_const(8'h03, 8'h05, 32'd15);
    start_job(1, 1'b0);
    stream(1, 1'b0);
    drain("t6", -1, 0);
    chk("t6.cycles", ocyc(), 64'd12);
    tick();
    chk("t6.done_count", 64'(d_done_cnt - dc0), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
